// File: rtl/rr_mux_sel_arbiter_pkg.sv
// Shared types and helpers for the round-robin select arbiter feeding the 4:1 mux stage.
package mux_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan ptr, ptr+1, ... (mod N_REQ) for the first request not masked by exclude.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] ptr,
                                    input logic [N_REQ-1:0] exclude);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand] && !exclude[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_mux_sel_arbiter_pick.sv
// Combinational rotate / priority-encode / rotate-back winner selection.
import mux_pkg::*;

module rr_priority_pick (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] exclude,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0]   masked;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [SEL_W-1:0]   offset;

  assign masked  = req & ~exclude;
  assign doubled = {masked, masked};
  // rotated[0] corresponds to requester ptr, so the lowest set bit is the winner.
  assign rotated = doubled[ptr +: N_REQ];

  always_comb begin
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = SEL_W'(i);
    end
  end

  assign found = |rotated;
  assign idx   = offset + ptr;

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of the downstream 4:1 mux, with a hold limit.
import mux_pkg::*;

module rr_mux_sel_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic             forced
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [7:0]       hold_cnt;

  logic [SEL_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_excl;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             at_limit;
  logic             owner_req;
  logic             release_now;

  // While busy the owner is sel; the same-edge re-arbitration starts after it and skips it.
  assign pick_ptr    = (state == BUSY) ? sel + SEL_W'(1) : ptr;
  assign pick_excl   = (state == BUSY) ? grant : '0;
  assign at_limit    = (hold_cnt == HOLD_LAST);
  assign owner_req   = req[sel];
  assign release_now = done || !owner_req || at_limit;

  rr_priority_pick u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .exclude (pick_excl),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      forced      <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      forced <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant       <= N_REQ'(1) << pick_idx;
            sel         <= pick_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            ptr    <= sel + SEL_W'(1);
            forced <= at_limit && !done && owner_req;
            if (pick_found) begin
              grant    <= N_REQ'(1) << pick_idx;
              sel      <= pick_idx;
              hold_cnt <= '0;
            end else begin
              grant       <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Scoreboarded random + directed bench for rr_mux_sel_arbiter against a rule-level model.
module tb_rr_mux_sel_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       grant_valid;
  logic       forced;

  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state: who owns the path, where priority starts, how long it has been held.
  int  m_busy = 0;
  int  m_owner = 0;
  int  m_ptr = 0;
  int  m_hold = 0;
  int  m_sel = 0;
  int  m_forced = 0;

  rr_mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .sel         (sel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .forced      (forced)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic int rr_search(input logic [3:0] r, input int start, input int skip);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (r[c] && c != skip) return c;
    end
    return -1;
  endfunction

  // Apply one cycle of inputs at the falling edge and queue the outputs expected after the next rise.
  task automatic step(input logic r, input logic [3:0] rq, input logic d);
    int  w;
    int  lim;
    int  rel;
    logic [3:0] g;
    rst  = r;
    req  = rq;
    done = d;
    if (r) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_sel = 0; m_forced = 0;
    end else begin
      m_forced = 0;
      if (m_busy == 0) begin
        w = rr_search(rq, m_ptr, -1);
        if (w >= 0) begin
          m_busy = 1; m_owner = w; m_sel = w; m_hold = 0;
        end
      end else begin
        lim = (m_hold == MAX_HOLD - 1);
        rel = d || !rq[m_owner] || lim;
        if (rel) begin
          m_forced = lim && !d && rq[m_owner];
          m_ptr = (m_owner + 1) % 4;
          w = rr_search(rq, m_ptr, m_owner);
          if (w >= 0) begin
            m_owner = w; m_sel = w; m_hold = 0;
          end else begin
            m_busy = 0;
          end
        end else if (m_hold < MAX_HOLD - 1) begin
          m_hold++;
        end
      end
    end
    g = (m_busy != 0) ? 4'(1 << m_owner) : 4'b0000;
    exp_q.push_back({2'(m_sel), g, (m_busy != 0), (m_forced != 0)});
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [7:0] got;
    logic [7:0] exp;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {sel, grant, grant_valid, forced};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL outputs cyc=%0d {sel,grant,gv,forced} got=%b_%b_%b_%b exp=%b_%b_%b_%b",
                   cyc, got[7:6], got[5:2], got[1], got[0], exp[7:6], exp[5:2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin : stimulus
    @(negedge clk);
    // single requester grant and release
    step(1, 4'b0000, 0);
    step(0, 4'b0001, 0);
    step(0, 4'b0001, 0);
    step(0, 4'b0001, 1);
    step(0, 4'b0000, 0);
    // all requesting, done every second cycle: full rotation with no bubbles
    step(1, 4'b0000, 0);
    for (int i = 0; i < 12; i++) step(0, 4'b1111, (i % 2) == 1);
    // lone requester hitting the hold limit, then regrant
    step(1, 4'b0000, 0);
    for (int i = 0; i < 14; i++) step(0, 4'b0100, 0);
    // owner drops req while another is waiting
    step(1, 4'b0000, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b1010, 0);
    step(0, 4'b1010, 0);
    step(0, 4'b1000, 0);
    step(0, 4'b1000, 1);
    // reset mid-grant, then priority restarts at channel 0
    step(1, 4'b0000, 0);
    for (int i = 0; i < 7; i++) step(0, 4'b0100, 0);
    step(1, 4'b0100, 0);
    step(0, 4'b1111, 0);
    step(0, 4'b1111, 1);
    // done coinciding with the hold limit is a normal release
    step(1, 4'b0000, 0);
    for (int i = 0; i < MAX_HOLD; i++) step(0, 4'b0011, 0);
    step(0, 4'b0011, 1);
    step(0, 4'b0011, 0);
    // done while idle is ignored
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 1);
    // randomized traffic
    begin
      logic [3:0] rq;
      rq = 4'b0000;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
        step($urandom_range(0, 99) == 0, rq, $urandom_range(0, 5) == 0);
      end
    end
    step(0, 4'b0000, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
Round-robin arbiter that sits directly upstream of the 4:1 mux stage and drives the mux's 2-bit select.
- Four requesters compete for the single mux output.
- The arbiter picks one winner, holds the select stable while that winner owns the path, then rotates priority so no requester starves.
- A hold limit forces rotation even if the owner never releases.

Parameters:
- N_REQ, 4, number of requesters (matches mux input count; only 4 is supported).
- SEL_W, 2, select width, equal to log2(N_REQ).
- MAX_HOLD, 8, maximum cycles one grant may persist before forced release; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request, level-sensitive.
- done  input  1  current owner releases the path this cycle.
- sel  output  SEL_W  select to the downstream mux; registered.
- grant  output  N_REQ  one-hot grant; registered; all-zero when idle.
- grant_valid  output  1  high while any grant is active.
- forced  output  1  one-cycle pulse when a grant ended because the MAX_HOLD limit was reached.

Behaviour:
- Reset values:
  - sel=0, grant=0, grant_valid=0, forced=0.
  - Priority pointer ptr=0, so channel 0 has top priority first.
  - hold_cnt=0; FSM in IDLE.
- FSM states:
  - IDLE: grant_valid=0. If req!=0 at a clock edge, choose winner w = first set bit scanning ptr, ptr+1, ... with mod-4 wrap. Then grant<=onehot(w), sel<=w, grant_valid<=1, hold_cnt<=0, go to BUSY. Latency is 1 cycle from req to grant.
  - BUSY: sel and grant stay frozen. hold_cnt increments each cycle, saturating at MAX_HOLD-1.
- Release from BUSY happens at the edge where any of these is true:
  - done=1;
  - req[owner]=0;
  - hold_cnt==MAX_HOLD-1.
- On release:
  - ptr<=owner+1 (mod 4).
  - forced<=1 only if the hold limit caused the release and neither done nor the req drop also applied.
- Back-to-back re-arbitration (no bubble):
  - If any req other than the owner is set at the release edge, arbitrate among them immediately from ptr=owner+1. Load the new grant/sel; stay in BUSY; hold_cnt<=0.
  - The releasing owner is excluded from that same-edge arbitration even if its req is still high.
  - Otherwise clear grant, set grant_valid<=0, go to IDLE. sel keeps its last value; the mux output is don't-care while idle.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - sel == index of set grant bit whenever grant_valid=1.
- done while IDLE: ignored.
- Simultaneous done and hold limit: treated as a normal release; forced=0.
- Reset mid-grant: all outputs return to reset values at that edge; ptr=0.
- A requester dropping req then re-raising it during another owner's grant has no effect until the next arbitration.

Decomposition:
- Shared package mux_pkg holds:
  - localparams N_REQ=4 and SEL_W=2;
  - enum arb_state_t {IDLE, BUSY};
  - function rr_pick(req, ptr, exclude) returning the winning index plus a found flag.
- One natural sub-module: rr_priority_pick, the combinational rotate, priority-encode, rotate-back logic. It is reusable by the mux stage's future wider variants.
- FSM, counters and output registers stay in the top block.

Test Plan:
- Reset, then req=0001: cycle 1 grant=0001, sel=00, grant_valid=1. done pulse -> next edge grant=0000, grant_valid=0, ptr=1.
- req=1111 held, done pulsed every 2 cycles: grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles between grants; sel follows 00, 01, 10, 11, 00.
- req=0100 held, done never asserted, MAX_HOLD=8: grant stays 0100 for exactly 8 cycles. Then forced pulses once, grant drops to 0000, and next edge regrants 0100 (only requester).
- Owner 0010 active while req=1010: clear req[1] -> same edge grant=1000, sel=11, forced=0.
- rst asserted while grant=0100, hold_cnt=5 -> next edge all outputs 0. With req=1111 afterwards, grant=0001 (ptr reset to 0).
- done and hold limit coincide for owner 0001 with req=0011 -> grant=0010, forced=0.
